// File: rtl/br_port_arbiter_pkg.sv
// Shared processor definitions: register-bank defaults and the port arbiter FSM states.
package br_port_arbiter_pkg;

    localparam int unsigned BR_WIDTH         = 16;
    localparam int unsigned BR_END_REGISTROS = 2;
    localparam int unsigned WAIT_CNT_BITS    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    function automatic logic [WAIT_CNT_BITS-1:0] sat_inc(
        input logic [WAIT_CNT_BITS-1:0] value,
        input logic [WAIT_CNT_BITS-1:0] limit
    );
        return (value >= limit) ? limit : value + 3'd1;
    endfunction

endpackage

// File: rtl/br_port_arbiter.sv
// Two-requester arbiter in front of the register bank: core has priority, the debug
// loader is forced through after MAX_WAIT consecutive core wins.
module br_port_arbiter
    import br_port_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH         = BR_WIDTH,
    parameter int unsigned END_REGISTROS = BR_END_REGISTROS,
    parameter int unsigned MAX_WAIT      = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     core_req,
    input  logic                     dbg_req,
    input  logic                     core_we,
    input  logic                     dbg_we,
    input  logic [END_REGISTROS-1:0] core_sel_a,
    input  logic [END_REGISTROS-1:0] dbg_sel_a,
    input  logic [END_REGISTROS-1:0] core_sel_b,
    input  logic [END_REGISTROS-1:0] dbg_sel_b,
    input  logic [WIDTH-1:0]         core_wdata,
    input  logic [WIDTH-1:0]         dbg_wdata,
    output logic                     core_ack,
    output logic                     dbg_ack,
    output logic [WIDTH-1:0]         rd_a,
    output logic [WIDTH-1:0]         rd_b,
    output logic                     br_hab_escrita,
    output logic [END_REGISTROS-1:0] br_sel_e_sa,
    output logic [END_REGISTROS-1:0] br_sel_sb,
    output logic [WIDTH-1:0]         br_e,
    input  logic [WIDTH-1:0]         br_a,
    input  logic [WIDTH-1:0]         br_b,
    output logic                     busy
);

    localparam logic [WAIT_CNT_BITS-1:0] MAX_W = WAIT_CNT_BITS'(MAX_WAIT);

    arb_state_t               state, state_next;
    logic [WAIT_CNT_BITS-1:0] wait_cnt, wait_cnt_next;
    logic                     arb_edge;
    logic                     dbg_wins;
    logic                     win_dbg;
    logic                     we_q;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        arb_edge      = (state == IDLE) && (core_req || dbg_req);
        dbg_wins      = dbg_req && (!core_req || (wait_cnt == MAX_W));

        unique case (state)
            IDLE:    if (core_req || dbg_req) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Starvation counter only moves on arbitration edges.
        if (arb_edge) begin
            if (dbg_wins || !dbg_req) wait_cnt_next = '0;
            else                      wait_cnt_next = sat_inc(wait_cnt, MAX_W);
        end

        busy           = (state != IDLE);
        br_hab_escrita = (state == ACCESS) && we_q;
        core_ack       = (state == RESP) && !win_dbg;
        dbg_ack        = (state == RESP) && win_dbg;
    end

    // The latched selects/data double as the bank outputs, so they hold outside ACCESS.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            win_dbg     <= 1'b0;
            we_q        <= 1'b0;
            br_sel_e_sa <= '0;
            br_sel_sb   <= '0;
            br_e        <= '0;
            rd_a        <= '0;
            rd_b        <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (arb_edge) begin
                win_dbg     <= dbg_wins;
                we_q        <= dbg_wins ? dbg_we     : core_we;
                br_sel_e_sa <= dbg_wins ? dbg_sel_a  : core_sel_a;
                br_sel_sb   <= dbg_wins ? dbg_sel_b  : core_sel_b;
                br_e        <= dbg_wins ? dbg_wdata  : core_wdata;
            end
            if ((state == ACCESS) && !we_q) begin
                rd_a <= br_a;
                rd_b <= br_b;
            end
        end
    end

endmodule

// File: tb/tb_br_port_arbiter.sv
// Directed and randomized checks of br_port_arbiter against a timestamp-based reference model.
module tb_br_port_arbiter;

    localparam int unsigned W  = 16;
    localparam int unsigned E  = 2;
    localparam int unsigned MW = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         core_req = 1'b0, dbg_req = 1'b0;
    logic         core_we = 1'b0, dbg_we = 1'b0;
    logic [E-1:0] core_sel_a = '0, dbg_sel_a = '0, core_sel_b = '0, dbg_sel_b = '0;
    logic [W-1:0] core_wdata = '0, dbg_wdata = '0;
    logic         core_ack, dbg_ack, br_hab_escrita, busy;
    logic [W-1:0] rd_a, rd_b, br_e, br_a, br_b;
    logic [E-1:0] br_sel_e_sa, br_sel_sb;

    br_port_arbiter #(.WIDTH(W), .END_REGISTROS(E), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .dbg_req(dbg_req), .core_we(core_we), .dbg_we(dbg_we),
        .core_sel_a(core_sel_a), .dbg_sel_a(dbg_sel_a),
        .core_sel_b(core_sel_b), .dbg_sel_b(dbg_sel_b),
        .core_wdata(core_wdata), .dbg_wdata(dbg_wdata),
        .core_ack(core_ack), .dbg_ack(dbg_ack), .rd_a(rd_a), .rd_b(rd_b),
        .br_hab_escrita(br_hab_escrita), .br_sel_e_sa(br_sel_e_sa), .br_sel_sb(br_sel_sb),
        .br_e(br_e), .br_a(br_a), .br_b(br_b), .busy(busy)
    );

    always #5 clock = ~clock;

    // Register bank environment driven purely by the DUT's bank interface.
    logic [W-1:0] bank [4] = '{default: '0};
    assign br_a = bank[br_sel_e_sa];
    assign br_b = bank[br_sel_sb];
    always @(posedge clock) if (br_hab_escrita) bank[br_sel_e_sa] <= br_e;

    // Reference model: everything derives from the edge index of the last arbitration.
    int           n = 0, n_a = -1000, wc = 0;
    logic         m_dbg = 1'b0, m_we = 1'b0;
    logic [E-1:0] m_sa = '0, m_sb = '0;
    logic [W-1:0] m_wd = '0, m_rd_a = '0, m_rd_b = '0;
    logic [W-1:0] mbank [4] = '{default: '0};
    int           total = 0, bad = 0;
    int           cnt_cack = 0, cnt_dack = 0, last_cack = 0, prev_cack = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_a = n - 1000; wc = 0;
        m_dbg = 0; m_we = 0; m_sa = '0; m_sb = '0; m_wd = '0; m_rd_a = '0; m_rd_b = '0;
    endtask

    task automatic model_edge();
        int d;
        bit dw;
        n++;
        if (!reset) begin
            model_reset();
            return;
        end
        d = n - n_a;
        if (d == 1) begin
            if (m_we) mbank[m_sa] = m_wd;
            else begin
                m_rd_a = mbank[m_sa];
                m_rd_b = mbank[m_sb];
            end
        end
        if (d >= 3 && (core_req || dbg_req)) begin
            dw = dbg_req && (!core_req || wc == MW);
            if (dw || !dbg_req) wc = 0;
            else if (wc < MW) wc++;
            m_dbg = dw;
            m_we  = dw ? dbg_we     : core_we;
            m_sa  = dw ? dbg_sel_a  : core_sel_a;
            m_sb  = dw ? dbg_sel_b  : core_sel_b;
            m_wd  = dw ? dbg_wdata  : core_wdata;
            n_a   = n;
        end
    endtask

    task automatic check_all();
        int e;
        e = n - n_a;
        chk("busy",     busy,           (e == 0 || e == 1));
        chk("hab",      br_hab_escrita, (e == 0 && m_we));
        chk("core_ack", core_ack,       (e == 1 && !m_dbg));
        chk("dbg_ack",  dbg_ack,        (e == 1 && m_dbg));
        chk("sel_e_sa", br_sel_e_sa,    m_sa);
        chk("sel_sb",   br_sel_sb,      m_sb);
        chk("br_e",     br_e,           m_wd);
        chk("rd_a",     rd_a,           m_rd_a);
        chk("rd_b",     rd_b,           m_rd_b);
        chk("wait_cnt", dut.wait_cnt,   wc);
        if (core_ack === 1'b1) begin cnt_cack++; prev_cack = last_cack; last_cack = n; end
        if (dbg_ack === 1'b1) cnt_dack++;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    task automatic do_access(input bit dbg, input bit we, input logic [E-1:0] sa,
                             input logic [E-1:0] sb, input logic [W-1:0] wd);
        if (dbg) begin dbg_req = 1; dbg_we = we; dbg_sel_a = sa; dbg_sel_b = sb; dbg_wdata = wd; end
        else begin core_req = 1; core_we = we; core_sel_a = sa; core_sel_b = sb; core_wdata = wd; end
        tick();
        core_req = 0; dbg_req = 0;
        tick();
        tick();
    endtask

    task automatic reset_pulse();
        #1 reset = 0;
        #1 model_reset();
        check_all();
        tick();
        reset = 1;
    endtask

    initial begin
        // Reset state, checked before any clock edge.
        #1 model_reset();
        check_all();
        tick();
        reset = 1;
        tick();

        // Core write: one-cycle write strobe with latched select/data, ack next cycle.
        core_req = 1; core_we = 1; core_sel_a = 2; core_sel_b = 1; core_wdata = 16'hABCD;
        tick();
        core_req = 0; core_wdata = 16'h1111; core_sel_a = 0;
        chk("t2_hab", br_hab_escrita, 1);
        chk("t2_sel", br_sel_e_sa, 2);
        chk("t2_e", br_e, 16'hABCD);
        tick();
        chk("t2_ack", core_ack, 1);
        chk("t2_hab_off", br_hab_escrita, 0);
        tick();
        chk("t2_idle", busy, 0);

        // Debug read of registers preloaded through the core port.
        do_access(0, 1, 1, 0, 16'h0012);
        do_access(0, 1, 3, 0, 16'h0034);
        dbg_req = 1; dbg_we = 0; dbg_sel_a = 1; dbg_sel_b = 3;
        tick();
        dbg_req = 0;
        chk("t3_hab", br_hab_escrita, 0);
        tick();
        chk("t3_ack", dbg_ack, 1);
        chk("t3_rd_a", rd_a, 16'h0012);
        chk("t3_rd_b", rd_b, 16'h0034);
        tick();

        // Both requesters held high: core x4 then dbg x1, repeating.
        cnt_cack = 0; cnt_dack = 0;
        core_req = 1; core_we = 0; dbg_req = 1; dbg_we = 0;
        for (int i = 0; i < 45; i++) tick();
        core_req = 0; dbg_req = 0;
        tick();
        chk("t4_core_acks", cnt_cack, 12);
        chk("t4_dbg_acks", cnt_dack, 3);

        // Reset during ACCESS of a write: strobe drops at once, no ack.
        core_req = 1; core_we = 1; core_sel_a = 0; core_wdata = 16'h5555;
        tick();
        core_req = 0;
        chk("t5_hab_before", br_hab_escrita, 1);
        #1 reset = 0;
        #1 chk("t5_hab_async", br_hab_escrita, 0);
        chk("t5_busy_async", busy, 0);
        model_reset();
        check_all();
        cnt_cack = 0;
        tick();
        reset = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_no_ack", cnt_cack, 0);

        // Core request held across its ack: back-to-back accesses 3 cycles apart.
        cnt_cack = 0;
        core_req = 1; core_we = 0;
        for (int i = 0; i < 5; i++) tick();
        core_req = 0;
        tick();
        chk("t6_acks", cnt_cack, 2);
        chk("t6_spacing", last_cack - prev_cack, 3);

        // One-cycle debug pulse while busy is dropped.
        cnt_dack = 0;
        core_req = 1;
        tick();
        core_req = 0; dbg_req = 1;
        tick();
        dbg_req = 0;
        tick();
        tick();
        chk("t7_no_dbg_ack", cnt_dack, 0);
        chk("t7_wait_cnt", dut.wait_cnt, 0);

        // Randomized traffic, including requesters changing inputs mid-access.
        for (int i = 0; i < 600; i++) begin
            core_req   = ($urandom_range(0, 3) != 0);
            dbg_req    = $urandom_range(0, 1) == 1;
            core_we    = $urandom_range(0, 1) == 1;
            dbg_we     = $urandom_range(0, 1) == 1;
            core_sel_a = E'($urandom_range(0, 3));
            core_sel_b = E'($urandom_range(0, 3));
            dbg_sel_a  = E'($urandom_range(0, 3));
            dbg_sel_b  = E'($urandom_range(0, 3));
            core_wdata = W'($urandom);
            dbg_wdata  = W'($urandom);
            if ($urandom_range(0, 99) == 0) reset_pulse();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
